rvc_compress_packer: RTL and testbench

- Encoder-side counterpart to the tracer's instruction decode patterns.
- Accepts a stream of 32-bit RV32 instruction words and compresses a fixed subset to 16-bit RVC parcels.
- Packs the resulting 16/32-bit parcels little-endian into a dense stream of 32-bit fetch words.
- Used by the trace-replay/stimulus path to build compressed instruction memories for the frontend.

---
 rtl/rvc_compress_packer.sv | 159 +++++++++++++++
 tb/tb_rvc_compress_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rvc_compress_packer.sv
// rvc_compress_packer: compresses a subset of RV32I instructions to RVC parcels
// and packs the resulting 16/32-bit parcels little-endian into 32-bit fetch words.
module rvc_compress_packer #(
  parameter bit EnableCompress = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        idle_o,
  output logic [31:0] cnt_compressed_o
);

  localparam int unsigned InstrW  = 32;
  localparam int unsigned ParcelW = 16;
  localparam int unsigned RegW    = 5;

  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpReg  = 7'b0110011;
  localparam logic [6:0] OpJalr = 7'b1100111;

  // Instruction fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [RegW-1:0] w_rd;
  logic [RegW-1:0] w_rs1;
  logic [RegW-1:0] w_rs2;
  logic [11:0]     w_imm;
  logic            w_imm_small;

  assign w_opcode    = instr_i[6:0];
  assign w_rd        = instr_i[11:7];
  assign w_funct3    = instr_i[14:12];
  assign w_rs1       = instr_i[19:15];
  assign w_rs2       = instr_i[24:20];
  assign w_funct7    = instr_i[31:25];
  assign w_imm       = instr_i[31:20];
  // imm fits in 6-bit signed range [-32,31] when bits 11..5 are all the sign bit
  assign w_imm_small = (w_imm[11:5] == {7{w_imm[5]}});

  logic                 w_match;
  logic [ParcelW-1:0]   w_c16;
  logic                 w_comp;

  // Combinational compression of the incoming instruction
  always_comb begin
    w_match = 1'b0;
    w_c16   = '0;
    if (instr_i == 32'h0000_0013) begin
      w_match = 1'b1;
      w_c16   = 16'h0001;
    end else if (w_opcode == OpImm && w_funct3 == 3'b000) begin
      if (w_rd != '0 && w_rs1 == w_rd && w_imm != '0 && w_imm_small) begin
        w_match = 1'b1;
        w_c16   = {3'b000, w_imm[5], w_rd, w_imm[4:0], 2'b01};
      end else if (w_rd != '0 && w_rs1 == '0 && w_imm_small) begin
        w_match = 1'b1;
        w_c16   = {3'b010, w_imm[5], w_rd, w_imm[4:0], 2'b01};
      end
    end else if (w_opcode == OpReg && w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
      if (w_rd != '0 && w_rs2 != '0 && w_rs1 == '0) begin
        w_match = 1'b1;
        w_c16   = {4'b1000, w_rd, w_rs2, 2'b10};
      end else if (w_rd != '0 && w_rs2 != '0 && w_rs1 == w_rd) begin
        w_match = 1'b1;
        w_c16   = {4'b1001, w_rd, w_rs2, 2'b10};
      end
    end else if (w_opcode == OpJalr && w_funct3 == 3'b000 && w_rd == '0 &&
                 w_imm == '0 && w_rs1 != '0) begin
      w_match = 1'b1;
      w_c16   = {4'b1000, w_rs1, 5'b00000, 2'b10};
    end
  end

  assign w_comp = EnableCompress && w_match;

  // State registers
  logic               r_res_v;
  logic [ParcelW-1:0] r_res;
  logic               r_valid;
  logic [InstrW-1:0]  r_data;
  logic [31:0]        r_cnt;

  logic               w_res_v_d;
  logic [ParcelW-1:0] w_res_d;
  logic               w_valid_d;
  logic [InstrW-1:0]  w_data_d;
  logic [31:0]        w_cnt_d;
  logic               w_out_free;
  logic               w_acc;

  assign w_out_free = !r_valid || ready_i;
  assign ready_o    = w_out_free && !flush_i;
  assign w_acc      = valid_i && ready_o;

  // Next-state: packing on accept, residue drain on flush
  always_comb begin
    w_res_v_d = r_res_v;
    w_res_d   = r_res;
    w_valid_d = r_valid && !ready_i;
    w_data_d  = r_data;
    w_cnt_d   = r_cnt;
    if (flush_i) begin
      if (r_res_v && w_out_free) begin
        w_valid_d = 1'b1;
        w_data_d  = {16'h0001, r_res};
        w_res_v_d = 1'b0;
      end
    end else if (w_acc) begin
      if (w_comp) begin
        w_cnt_d = r_cnt + 32'd1;
        if (r_res_v) begin
          w_valid_d = 1'b1;
          w_data_d  = {w_c16, r_res};
          w_res_v_d = 1'b0;
        end else begin
          w_res_d   = w_c16;
          w_res_v_d = 1'b1;
        end
      end else if (r_res_v) begin
        w_valid_d = 1'b1;
        w_data_d  = {instr_i[15:0], r_res};
        w_res_d   = instr_i[31:16];
      end else begin
        w_valid_d = 1'b1;
        w_data_d  = instr_i;
      end
    end
  end

  // Register update with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_v <= 1'b0;
      r_res   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_res_v <= w_res_v_d;
      r_res   <= w_res_d;
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign valid_o          = r_valid;
  assign data_o           = r_data;
  assign idle_o           = !r_res_v && !r_valid;
  assign cnt_compressed_o = r_cnt;

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed self-checking bench for rvc_compress_packer.
module tb_rvc_compress_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        idle_o;
  logic [31:0] cnt_o;

  logic        nc_ready_o;
  logic        nc_valid_o;
  logic [31:0] nc_data_o;
  logic        nc_idle_o;
  logic [31:0] nc_cnt_o;

  int n_total = 0;
  int n_bad   = 0;
  int xfer_cnt = 0;
  logic [31:0] exp_cnt;

  always #5 clk_i = ~clk_i;

  rvc_compress_packer #(.EnableCompress(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .instr_i(instr_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .idle_o(idle_o), .cnt_compressed_o(cnt_o)
  );

  rvc_compress_packer #(.EnableCompress(1'b0)) dut_nc (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(nc_ready_o), .instr_i(instr_i), .valid_o(nc_valid_o), .ready_i(ready_i),
    .data_o(nc_data_o), .idle_o(nc_idle_o), .cnt_compressed_o(nc_cnt_o)
  );

  // Count output handshakes of the main instance
  always @(posedge clk_i) if (rst_ni && valid_o && ready_i) xfer_cnt <= xfer_cnt + 1;

  typedef struct {
    logic [31:0] instr;
    bit          comp;
    logic [15:0] c16;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    valid_i = 1'b1;
    instr_i = ins;
    tick();
    valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int x0;
    vecs[0]  = '{32'h0050_8093, 1'b1, 16'h0095}; // addi x1,x1,5
    vecs[1]  = '{32'hFFF0_0113, 1'b1, 16'h517D}; // li x2,-1
    vecs[2]  = '{32'h0000_0013, 1'b1, 16'h0001}; // nop
    vecs[3]  = '{32'h0200_8093, 1'b0, 16'h0000}; // addi x1,x1,32
    vecs[4]  = '{32'h0011_0093, 1'b0, 16'h0000}; // addi x1,x2,1
    vecs[5]  = '{32'h0010_0013, 1'b0, 16'h0000}; // addi x0,x0,1
    vecs[6]  = '{32'h0040_01B3, 1'b1, 16'h8192}; // mv x3,x4
    vecs[7]  = '{32'h0062_82B3, 1'b1, 16'h929A}; // add x5,x5,x6
    vecs[8]  = '{32'h4062_82B3, 1'b0, 16'h0000}; // sub x5,x5,x6
    vecs[9]  = '{32'h0000_8067, 1'b1, 16'h8082}; // jr x1
    vecs[10] = '{32'h0001_00E7, 1'b0, 16'h0000}; // jalr x1,0(x2)
    vecs[11] = '{32'hFE00_8093, 1'b1, 16'h1081}; // addi x1,x1,-32
    vecs[12] = '{32'h0000_8093, 1'b0, 16'h0000}; // addi x1,x1,0
    vecs[13] = '{32'h01F0_0393, 1'b1, 16'h43FD}; // li x7,31
    vecs[14] = '{32'hFDF0_8093, 1'b0, 16'h0000}; // addi x1,x1,-33
    vecs[15] = '{32'h1234_52B7, 1'b0, 16'h0000}; // lui x5,0x12345

    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; instr_i = '0; ready_i = 1'b1;
    exp_cnt = '0;
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_cnt", cnt_o, 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("rst_ready", 32'(ready_o), 32'd1);

    // Two compressible instructions pack into one word
    send(32'h0050_8093);
    chk("pair_first_valid", 32'(valid_o), 32'd0);
    send(32'hFFF0_0113);
    chk("pair_valid", 32'(valid_o), 32'd1);
    chk("pair_data", data_o, 32'h517D_0095);
    exp_cnt = 32'd2;
    tick();
    chk("pair_cnt", cnt_o, exp_cnt);
    chk("pair_idle", 32'(idle_o), 32'd1);

    // Uncompressible with empty residue passes through
    send(32'h1234_52B7);
    chk("lui_data", data_o, 32'h1234_52B7);
    chk("lui_cnt", cnt_o, exp_cnt);
    tick();

    // Split word then flush drain
    send(32'h0050_8093);
    send(32'h1234_52B7);
    exp_cnt = exp_cnt + 1;
    chk("split_data", data_o, 32'h52B7_0095);
    chk("split_idle", 32'(idle_o), 32'd0);
    flush_i = 1'b1;
    tick();
    chk("flush_data", data_o, 32'h0001_1234);
    chk("flush_valid", 32'(valid_o), 32'd1);
    chk("flush_ready", 32'(ready_o), 32'd0);
    tick();
    chk("flush_idle", 32'(idle_o), 32'd1);
    tick();
    chk("flush_hold_valid", 32'(valid_o), 32'd0);
    flush_i = 1'b0;
    tick();

    // Backpressure: output held, no loss or duplication
    x0 = xfer_cnt;
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = 32'h1234_52B7;
    tick();
    instr_i = 32'h0011_0093;
    chk("bp_ready", 32'(ready_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_data_hold", data_o, 32'h1234_52B7);
      chk("bp_valid_hold", 32'(valid_o), 32'd1);
    end
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("bp_next_data", data_o, 32'h0011_0093);
    tick();
    chk("bp_drained", 32'(valid_o), 32'd0);
    chk("bp_xfers", 32'(xfer_cnt - x0), 32'd2);

    // Table-driven single-instruction vectors
    for (int k = 0; k < 16; k++) begin
      send(vecs[k].instr);
      if (vecs[k].comp) begin
        exp_cnt = exp_cnt + 1;
        chk("vec_comp_novalid", 32'(valid_o), 32'd0);
        chk("vec_comp_busy", 32'(idle_o), 32'd0);
        if (vecs[k].instr == 32'h0000_0013) begin
          chk("nc_nop_data", nc_data_o, 32'h0000_0013);
          chk("nc_nop_valid", 32'(nc_valid_o), 32'd1);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("vec_comp_data", data_o, {16'h0001, vecs[k].c16});
        chk("vec_comp_valid", 32'(valid_o), 32'd1);
      end else begin
        chk("vec_pass_data", data_o, vecs[k].instr);
        chk("vec_pass_valid", 32'(valid_o), 32'd1);
      end
      tick();
      chk("vec_idle", 32'(idle_o), 32'd1);
      chk("vec_cnt", cnt_o, exp_cnt);
    end
    chk("nc_idle", 32'(nc_idle_o), 32'd1);
    chk("nc_cnt", nc_cnt_o, 32'd0);

    // Reset with residue and pending output
    send(32'h0050_8093);
    ready_i = 1'b0;
    send(32'h0095_02B7);
    chk("prerst_data", data_o, 32'h02B7_0095);
    chk("prerst_idle", 32'(idle_o), 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_idle", 32'(idle_o), 32'd1);
    chk("midrst_cnt", cnt_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    ready_i = 1'b1;
    tick();
    send(32'h1234_52B7);
    chk("postrst_data", data_o, 32'h1234_52B7);
    chk("postrst_valid", 32'(valid_o), 32'd1);
    tick();
    chk("postrst_idle", 32'(idle_o), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
